// File: rtl/sad_controller.sv
// SAD sequencer: walks ROM pair addresses 0..len-1, accumulates |A-B|
// and publishes the sum with a one-cycle done pulse.
module sad_controller #(
  parameter int unsigned N      = 256,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 41
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data_a,
  input  logic [DATA_W-1:0] rom_data_b,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sad
);

  localparam int unsigned DIFF_W = DATA_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   cnt, cnt_d;
  logic [ACC_W-1:0]    acc, acc_d;
  logic [DIFF_W-1:0]   diff_q, diff_d;
  logic                diff_v, diff_v_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                busy_d, done_d;
  logic [ACC_W-1:0]    sad_d;

  logic [ADDR_W-1:0]   len_clamp;
  logic [DIFF_W-1:0]   a_ext, b_ext, delta, abs_diff;

  // Operands are sign-extended by one bit so the difference can never overflow.
  always_comb begin
    a_ext    = {rom_data_a[DATA_W-1], rom_data_a};
    b_ext    = {rom_data_b[DATA_W-1], rom_data_b};
    delta    = a_ext - b_ext;
    abs_diff = delta[DIFF_W-1] ? (~delta + DIFF_W'(1)) : delta;
  end

  assign len_clamp = (len > ADDR_W'(N)) ? ADDR_W'(N) : len;

  // Next-state and next-value logic for every register.
  always_comb begin
    state_d  = state;
    len_d    = len_q;
    cnt_d    = cnt;
    acc_d    = acc;
    diff_d   = diff_q;
    diff_v_d = diff_v;
    done_d   = 1'b0;
    sad_d    = sad;
    busy_d   = 1'b0;
    addr_d   = '0;

    if ((state == ST_RUN || state == ST_DRAIN) && diff_v) begin
      acc_d = acc + ACC_W'(diff_q);
    end

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          len_d    = len_clamp;
          cnt_d    = '0;
          acc_d    = '0;
          diff_v_d = 1'b0;
          state_d  = (len_clamp == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d   = abs_diff;
        diff_v_d = 1'b1;
        cnt_d    = cnt + ADDR_W'(1);
        if (cnt == len_q - ADDR_W'(1)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        diff_v_d = 1'b0;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        sad_d   = acc;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort cancels an active run without touching the published result.
    if (abort && state != ST_IDLE) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      sad_d    = sad;
      diff_v_d = 1'b0;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    addr_d = (state_d == ST_RUN) ? cnt_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      cnt      <= '0;
      acc      <= '0;
      diff_q   <= '0;
      diff_v   <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sad      <= '0;
    end else begin
      state    <= state_d;
      len_q    <= len_d;
      cnt      <= cnt_d;
      acc      <= acc_d;
      diff_q   <= diff_d;
      diff_v   <= diff_v_d;
      rom_addr <= addr_d;
      busy     <= busy_d;
      done     <= done_d;
      sad      <= sad_d;
    end
  end

endmodule

// File: tb/tb_sad_controller.sv
// Self-checking bench for sad_controller with an array-backed ROM and a
// plain-arithmetic SAD reference model.
module tb_sad_controller;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [8:0]  len;
  logic [8:0]  rom_addr;
  logic [31:0] rom_data_a;
  logic [31:0] rom_data_b;
  logic        busy;
  logic        done;
  logic [40:0] sad;

  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];

  int checks;
  int failures;

  sad_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .rom_addr(rom_addr), .rom_data_a(rom_data_a), .rom_data_b(rom_data_b),
    .busy(busy), .done(done), .sad(sad)
  );

  assign rom_data_a = (rom_addr < 9'd256) ? rom_a[rom_addr[7:0]] : 32'd0;
  assign rom_data_b = (rom_addr < 9'd256) ? rom_b[rom_addr[7:0]] : 32'd0;

  always #5 clk = ~clk;

  function automatic logic [40:0] model_sad(int l_req);
    longint s;
    longint d;
    int l;
    s = 0;
    l = (l_req > 256) ? 256 : l_req;
    for (int i = 0; i < l; i++) begin
      d = longint'($signed(rom_a[i])) - longint'($signed(rom_b[i]));
      if (d < 0) d = -d;
      s += d;
    end
    return s[40:0];
  endfunction

  task automatic load_image();
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = $urandom;
      rom_b[i] = $urandom;
    end
    rom_a[0] = 32'hFFFFFFB7; rom_b[0] = 32'h000000D5;
    rom_a[1] = -32'sd178;    rom_b[1] = -32'sd16;
    rom_a[2] = 32'd140;      rom_b[2] = -32'sd193;
  endtask

  // Pulse start for one edge; returns positioned 1ns after that edge (cycle k=0).
  task automatic pulse_start(int l_req);
    start = 1'b1;
    len   = 9'(l_req);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Start a run and check done timing, busy length, address walk and result.
  task automatic run_check(string name, int l_req, logic [40:0] exp_sad, bit restart_busy);
    int l, done_at, done_cnt, busy_cnt, addr_err, exp_done, exp_busy;
    l = (l_req > 256) ? 256 : l_req;
    done_at = -1; done_cnt = 0; busy_cnt = 0; addr_err = 0;
    exp_done = (l == 0) ? 1 : l + 2;
    exp_busy = (l == 0) ? 0 : l + 1;
    pulse_start(l_req);
    for (int k = 0; k < l + 6; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k < l && rom_addr !== 9'(k)) addr_err++;
      start = restart_busy && (k == 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++;
    if (done_at !== exp_done) begin
      failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_at, exp_done);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL %s done_width got=%0d exp=1", name, done_cnt);
    end
    checks++;
    if (busy_cnt !== exp_busy) begin
      failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cnt, exp_busy);
    end
    checks++;
    if (addr_err !== 0) begin
      failures++; $display("FAIL %s rom_addr_walk errors=%0d exp=0", name, addr_err);
    end
    checks++;
    if (sad !== exp_sad) begin
      failures++; $display("FAIL %s sad got=%0d exp=%0d", name, sad, exp_sad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, sad, rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_values busy=%b done=%b sad=%0d addr=%0d exp=all_zero", busy, done, sad, rom_addr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_image();
    load_image();
    run_check("len1", 1, 41'd286, 1'b0);
    run_check("len3_restart_ignored", 3, 41'd781, 1'b1);
  endtask

  task automatic test_reset_midrun();
    pulse_start(10);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sad, rom_addr} !== '0) begin
      failures++;
      $display("FAIL reset_midrun busy=%b done=%b sad=%0d addr=%0d exp=all_zero", busy, done, sad, rom_addr);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("after_reset_len1", 1, 41'd286, 1'b0);
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 32'h7FFFFFFF;
      rom_b[i] = 32'h80000000;
    end
    run_check("len256_extreme", 256, 41'd1099511627520, 1'b0);
    run_check("len300_clamped", 300, 41'd1099511627520, 1'b0);
  endtask

  task automatic test_random();
    int l;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 256; i++) begin
        rom_a[i] = $urandom;
        rom_b[i] = $urandom;
        if ($urandom_range(0, 7) == 0) rom_a[i] = 32'h80000000;
        if ($urandom_range(0, 7) == 0) rom_b[i] = 32'h7FFFFFFF;
      end
      l = (r == 0) ? 0 : int'($urandom_range(1, 300));
      run_check($sformatf("random%0d_len%0d", r, l), l, model_sad(l), 1'b0);
    end
  endtask

  task automatic test_abort();
    int done_cnt, busy_after;
    load_image();
    run_check("abort_prior_len3", 3, 41'd781, 1'b0);
    pulse_start(10);
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || rom_addr !== 9'd0) begin
      failures++; $display("FAIL abort_to_idle busy=%b addr=%0d exp=0,0", busy, rom_addr);
    end
    done_cnt = 0; busy_after = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) done_cnt++;
      if (busy) busy_after++;
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt !== 0 || busy_after !== 0) begin
      failures++; $display("FAIL abort_quiet done_cycles=%0d busy_cycles=%0d exp=0,0", done_cnt, busy_after);
    end
    checks++;
    if (sad !== 41'd781) begin
      failures++; $display("FAIL abort_sad_held got=%0d exp=781", sad);
    end
    run_check("len0_after_abort", 0, 41'd0, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    int busy_cnt, done_cnt;
    load_image();
    start = 1'b1; abort = 1'b1; len = 9'd5;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_cnt !== 0 || done_cnt !== 0) begin
      failures++; $display("FAIL start_abort_idle busy_cycles=%0d done_cycles=%0d exp=0,0", busy_cnt, done_cnt);
    end
    run_check("after_start_abort_len2", 2, model_sad(2), 1'b0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0;
    checks = 0; failures = 0;
    load_image();
    test_reset();
    test_image();
    test_reset_midrun();
    test_max_len();
    test_random();
    test_abort();
    test_start_abort_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
